// File: rtl/dmem_bus_arbiter_if.sv
// Two-core data-memory bus bundle: core request/response side plus the memory side.
// The arbiter attaches through the slave modport; the requesting environment uses master.
interface dmem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [1:0]          req;
    logic [1:0]          we;
    logic [2*ADDR_W-1:0] addr;
    logic [2*DATA_W-1:0] wdata;
    logic [1:0]          done;
    logic [DATA_W-1:0]   rdata;
    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic [1:0]          inv_valid;
    logic [ADDR_W-1:0]   inv_addr;

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output done, rdata, mem_en, mem_we, mem_addr, mem_wdata, inv_valid, inv_addr
    );

    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  done, rdata, mem_en, mem_we, mem_addr, mem_wdata, inv_valid, inv_addr
    );
endinterface

// File: rtl/dmem_bus_arbiter.sv
// Round-robin arbiter giving two cores access to one data memory port (IDLE/ACCESS/RESP).
// Define SNOOP_INV_EN to pulse a snoop-invalidate to the other core on a granted store.
module dmem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic               clk,
    input  logic               reset,
    dmem_bus_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_e              state_q;
    logic                rr_q;
    logic                gnt_q;
    logic [3:0]          cnt_q;
    logic [1:0]          done_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [1:0]          inv_valid_q;
    logic [ADDR_W-1:0]   inv_addr_q;

    logic                gnt_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;

    // rr_q only breaks ties; a lone requester always wins.
    always_comb begin
        gnt_d   = (bus.req == 2'b11) ? rr_q : bus.req[1];
        addr_d  = gnt_d ? bus.addr[ADDR_W +: ADDR_W]  : bus.addr[0 +: ADDR_W];
        wdata_d = gnt_d ? bus.wdata[DATA_W +: DATA_W] : bus.wdata[0 +: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            gnt_q       <= 1'b0;
            cnt_q       <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            inv_valid_q <= '0;
            inv_addr_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        gnt_q       <= gnt_d;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= bus.we[gnt_d];
                        mem_addr_q  <= addr_d;
                        mem_wdata_q <= wdata_d;
                        cnt_q       <= CNT_INIT;
                        state_q     <= ACCESS;
`ifdef SNOOP_INV_EN
                        // Invalidate goes to the core that did not issue the store.
                        inv_valid_q <= bus.we[gnt_d] ? (gnt_d ? 2'b01 : 2'b10) : 2'b00;
                        inv_addr_q  <= bus.we[gnt_d] ? addr_d : '0;
`endif
                    end
                end
                ACCESS: begin
                    inv_valid_q <= '0;
                    inv_addr_q  <= '0;
                    if (cnt_q == 4'd0) begin
                        mem_en_q    <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        rdata_q     <= bus.mem_rdata;
                        done_q      <= gnt_q ? 2'b10 : 2'b01;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    done_q  <= '0;
                    rr_q    <= ~gnt_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.done      = done_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.inv_valid = inv_valid_q;
    assign bus.inv_addr  = inv_addr_q;
endmodule

// File: doc/dmem_bus_arbiter.md
DMEM_BUS_ARBITER -- requirements
Module: dmem_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of the request and memory address.
REQ-002 SHALL have parameter DATA_W, default 32, width of the data buses.
REQ-003 SHALL have parameter MEM_LAT, default 2, the number of ACCESS cycles per transaction; legal range is 1..15.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic triggers on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port req, input, 2 bits: per-core transaction request; bit i belongs to core i.
REQ-007 SHALL have port we, input, 2 bits: per-core write enable (1 = store, 0 = load).
REQ-008 SHALL have port addr, input, 2*ADDR_W bits: per-core address; core i uses slice [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port wdata, input, 2*DATA_W bits: per-core store data, sliced the same way as addr.
REQ-010 SHALL have port done, output, 2 bits: one-cycle completion pulse per core.
REQ-011 SHALL have port rdata, output, DATA_W bits: load data, valid while done is high.
REQ-012 SHALL have memory-side ports mem_en (output, 1), mem_we (output, 1), mem_addr (output, ADDR_W), mem_wdata (output, DATA_W) and mem_rdata (input, DATA_W).
REQ-013 SHALL have port inv_valid, output, 2 bits: per-core snoop-invalidate pulse.
REQ-014 SHALL have port inv_addr, output, ADDR_W bits: address to invalidate.

Function
REQ-015 SHALL implement the FSM IDLE -> ACCESS -> RESP -> IDLE.
REQ-016 IDLE: if any req bit is high at a rising edge, SHALL grant exactly one core and latch that core's we, addr and wdata; next state is ACCESS.
REQ-017 Grant with both req bits high: SHALL grant the core indicated by rr_ptr. With one req bit high: SHALL grant that core regardless of rr_ptr.
REQ-018 ACCESS: SHALL drive mem_en=1 and the latched values on mem_we, mem_addr and mem_wdata for exactly MEM_LAT cycles, counted by a down-counter.
REQ-019 On the last ACCESS cycle, SHALL register mem_rdata into rdata; next state is RESP.
REQ-020 RESP: SHALL assert done[granted]=1 for exactly one cycle, then set rr_ptr to the non-granted core; next state is IDLE.
REQ-021 Latency SHALL be: req sampled at edge N; mem_en high during cycles N+1..N+MEM_LAT; done high in cycle N+MEM_LAT+1.
REQ-022 req, we, addr and wdata SHALL be ignored outside IDLE. Deasserting req mid-transaction SHALL NOT abort the transaction.
REQ-023 A requester SHALL drop req at the edge where done is sampled; a req still high in IDLE after RESP SHALL be treated as a new request.
REQ-024 rdata SHALL hold its last value outside RESP; its value after a store is don't-care.
REQ-025 done and mem_en SHALL never be high in the same cycle; at most one done bit SHALL be high at any time.

Reset
REQ-026 While reset is high, SHALL force state=IDLE, rr_ptr=0, counter=0, and all outputs to 0 (done, rdata, mem_en, mem_we, mem_addr, mem_wdata, inv_valid, inv_addr).
REQ-027 Reset asserted mid-transaction SHALL abort the transaction: no done is issued, and the first post-reset grant follows REQ-017 with rr_ptr=0.

Configuration
REQ-028 Macro SNOOP_INV_EN defined: for a granted store, SHALL assert inv_valid[other core]=1 and inv_addr=latched addr during the first ACCESS cycle only. Loads SHALL produce no invalidate.
REQ-029 Macro SNOOP_INV_EN undefined: the inv_valid and inv_addr ports SHALL remain present and SHALL be held at 0.

Verification
REQ-030 MEM_LAT=2, core0 load addr=0x10, mem_rdata=0xDEADBEEF -> mem_en high in cycles 1-2, done=2'b01 in cycle 3, rdata=0xDEADBEEF.
REQ-031 Both cores request together after reset -> core0 is served first with done=2'b01. If core1 holds req, it is granted next with done=2'b10 in cycle 7. Then rr_ptr=0.
REQ-032 Core1 alone requests with rr_ptr=0 -> core1 is granted immediately, done=2'b10 in cycle 3.
REQ-033 SNOOP_INV_EN defined, core0 store addr=0x40 wdata=0x55 -> cycle 1: mem_we=1, mem_wdata=0x55, inv_valid=2'b10, inv_addr=0x40. Undefined: inv_valid stays 0.
REQ-034 Reset asserted in cycle 2 of a core1 access -> no done is issued, all outputs read 0 the next cycle, and a subsequent dual request grants core0 first.
REQ-035 Core0 drops req during ACCESS -> the transaction still completes with done=2'b01.
